// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - bi, giving difference and borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);
    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~x & bi) | (y & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per cycle through a single full_subtractor.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave io_bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of range 1..64");
    end

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_bout;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_diff;
    logic             w_bo;
    logic [WIDTH-1:0] w_d_next;

    full_subtractor u_fs (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bi   (r_borrow),
        .diff (w_diff),
        .bo   (w_bo)
    );

    // Diff bits enter at the MSB so the result is LSB-aligned after WIDTH shifts.
    if (WIDTH == 1) begin : g_d_one
        assign w_d_next = w_diff;
    end else begin : g_d_wide
        assign w_d_next = {w_diff, r_d[WIDTH-1:1]};
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_a_sr     <= io_bus.a;
                        r_b_sr     <= io_bus.b;
                        r_borrow   <= io_bus.bin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_d      <= w_d_next;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_bout      <= w_bo;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.d         = r_d;
    assign io_bus.bout      = r_bout;

    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(io_bus.out_valid && io_bus.in_ready));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (io_bus.out_valid && !io_bus.out_ready) |=> ($stable(io_bus.d) && $stable(io_bus.bout)));

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH 8, 1 and 32.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(1))  if1 ();
    serial_subtractor_if #(.WIDTH(32)) if32 ();

    serial_subtractor #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .io_bus(if8));
    serial_subtractor #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .io_bus(if1));
    serial_subtractor #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .io_bus(if32));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; hold > 0 keeps out_ready low for that many DONE cycles.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb, input int hold, input string tag);
        int lat;
        check({tag, " in_ready idle"}, 64'(if8.in_ready), 64'd1);
        if8.a = a; if8.b = b; if8.bin = bin; if8.in_valid = 1'b1;
        if8.out_ready = (hold == 0);
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        if8.a = ~a; if8.b = ~b; if8.bin = ~bin;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (if8.out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " d"}, 64'(if8.d), 64'(ed));
        check({tag, " bout"}, 64'(if8.bout), 64'(eb));
        check({tag, " in_ready busy"}, 64'(if8.in_ready), 64'd0);
        for (int h = 1; h <= hold; h++) begin
            if8.in_valid = 1'b1;
            if8.a = 8'(h * 37);
            @(posedge clk); #1;
            check({tag, " hold valid"}, 64'(if8.out_valid), 64'd1);
            check({tag, " hold d"}, 64'(if8.d), 64'(ed));
            check({tag, " hold bout"}, 64'(if8.bout), 64'(eb));
            check({tag, " hold in_ready"}, 64'(if8.in_ready), 64'd0);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " in_ready after hs"}, 64'(if8.in_ready), 64'd1);
        check({tag, " out_valid after hs"}, 64'(if8.out_valid), 64'd0);
        check({tag, " d kept"}, 64'(if8.d), 64'(ed));
    endtask

    initial begin
        // {bout,d} for WIDTH=1, indexed by {a,b,bin}
        logic [1:0] tab1 [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
        logic [32:0] exp33;
        logic [31:0] ra, rb;
        logic        rbin, hs;
        int          lat, n_hs;

        if8.in_valid = 0;  if8.a = 0;  if8.b = 0;  if8.bin = 0;  if8.out_ready = 1;
        if1.in_valid = 0;  if1.a = 0;  if1.b = 0;  if1.bin = 0;  if1.out_ready = 1;
        if32.in_valid = 0; if32.a = 0; if32.b = 0; if32.bin = 0; if32.out_ready = 1;

        #12;
        check("rst in_ready", 64'(if8.in_ready), 64'd1);
        check("rst out_valid", 64'(if8.out_valid), 64'd0);
        check("rst d", 64'(if8.d), 64'd0);
        check("rst bout", 64'(if8.bout), 64'd0);
        check("rst w32 d", 64'(if32.d), 64'd0);
        check("rst w1 in_ready", 64'(if1.in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 0, "w8 5A-3C");
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, "w8 00-01");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, "w8 FF-FF-1");
        op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0, "w8 80-7F-1");
        op8(8'h10, 8'h03, 1'b0, 8'h0D, 1'b0, 5, "w8 backpressure");

        // Reset after four RUN edges discards the operation.
        if8.a = 8'hC3; if8.b = 8'h11; if8.bin = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst in_ready", 64'(if8.in_ready), 64'd1);
        check("midrst out_valid", 64'(if8.out_valid), 64'd0);
        check("midrst d", 64'(if8.d), 64'd0);
        check("midrst bout", 64'(if8.bout), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        op8(8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 0, "w8 after rst");

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            if1.a = v[2]; if1.b = v[1]; if1.bin = v[0]; if1.in_valid = 1'b1;
            @(posedge clk); #1;
            if1.in_valid = 1'b0;
            lat = 0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                if (if1.out_valid) begin lat = k; break; end
            end
            check($sformatf("w1 latency %0d", i), 64'(lat), 64'd1);
            check($sformatf("w1 result %0d", i), 64'({if1.bout, if1.d}), 64'(tab1[i]));
            @(posedge clk); #1;
        end

        n_hs = 0;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            check("w32 ready", 64'(if32.in_ready), 64'd1);
            ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 32'h0; rb = 32'hFFFF_FFFF; rbin = 1'b1; end
            exp33 = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
            if32.a = ra; if32.b = rb; if32.bin = rbin; if32.in_valid = 1'b1;
            if32.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            hs = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if32.in_valid = 1'($urandom_range(0, 1));
                if32.a = $urandom;
                if32.out_ready = 1'($urandom_range(0, 1));
                hs = if32.out_valid && if32.out_ready;
                if (hs) begin
                    check($sformatf("w32 op %0d", i), 64'({if32.bout, if32.d}), 64'(exp33));
                    n_hs++;
                end
                @(posedge clk); #1;
                if (hs) break;
            end
            if32.in_valid = 1'b0;
            check($sformatf("w32 hs %0d", i), 64'(hs), 64'd1);
            check($sformatf("w32 drop %0d", i), 64'(if32.out_valid), 64'd0);
        end
        check("w32 handshake count", 64'(n_hs), 64'd1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor that computes d = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first, using a single registered borrow.
- It is the inverse-direction partner of the ripple serial_adder arithmetic path and is intended for area-constrained datapaths.
- Operands enter and the result leaves through valid/ready handshakes, so the block can sit between pipeline stages.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set a/b/bin is valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  d/bout are valid.
- out_ready  input  1  consumer accepts the result.
- d  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- States are IDLE, RUN and DONE. The encoding is an enum in the package.
- Reset (async assert, any state):
  - state goes to IDLE; in_ready=1, out_valid=0, d=0, bout=0;
  - the operand shift registers, borrow register and bit counter clear to 0;
  - any in-flight operation is discarded with no partial output.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a, b into shift registers, load borrow register with bin, set bit counter to 0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge, feed a_sr[0], b_sr[0] and the borrow register through one full_subtractor.
  - Shift the diff bit into the result register from the MSB end, which leaves it LSB-aligned after WIDTH shifts.
  - Shift both operand registers right by 1, update the borrow register with the stage borrow, and increment the counter.
  - When the counter reaches WIDTH-1 on this edge, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - d and bout are stable (registered) until the handshake completes.
  - An edge with out_ready=1 returns the block to IDLE.
  - d and bout keep their values after the handshake; only out_valid drops.
- Latency: with the accept edge as E0, out_valid is first high after edge E(WIDTH). For WIDTH=8 that is 8 cycles after accept.
- Throughput: at most one operation per WIDTH+2 cycles. There is no overlap: in_ready is high only in IDLE.
- Backpressure: while out_ready=0 in DONE, the block holds indefinitely with outputs constant.
- in_valid in RUN/DONE is ignored. Inputs a/b/bin may change freely after acceptance.
- Counter width is $clog2(WIDTH) with a minimum of 1. For WIDTH=1, the first RUN edge goes directly to DONE.
- Arithmetic is unsigned modulo 2^WIDTH. bout is the final stage borrow.
- No X on any output after reset.
- Assertions (simulation only):
  - out_valid and in_ready are never both high;
  - d and bout are stable while out_valid && !out_ready.

Decomposition:
- Package serial_arith_pkg holds:
  - the state_e enum {IDLE, RUN, DONE};
  - the localparam MAX_WIDTH=64, used for the parameter-range check.
- Sub-module full_subtractor is combinational:
  - inputs x, y, bi; outputs diff, bo;
  - diff = x^y^bi;
  - bo = (~x&y) | (~x&bi) | (y&bi).
- serial_subtractor instantiates exactly one full_subtractor.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, bin=0, out_ready=1 -> out_valid rises 8 cycles after accept; d=0x1E, bout=0; in_ready returns to 1 the cycle after the output handshake.
- WIDTH=8: a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 -> d=0xFF, bout=1. Then a=0x80, b=0x7F, bin=1 -> d=0x00, bout=0.
- Backpressure, WIDTH=8: a=0x10, b=0x03, out_ready held 0 for 5 cycles after out_valid -> d=0x0D, bout=0 constant; in_ready=0 throughout; in_valid pulses are ignored; handshake on cycle 6.
- Reset mid-operation, WIDTH=8: assert rst after 4 RUN cycles -> immediately in_ready=1, out_valid=0, d=0. Next op a=0x03, b=0x01 -> d=0x02, bout=0 with normal latency.
- WIDTH=1: (a,b,bin) over all 8 combinations -> d/bout match the truth table; out_valid rises 1 cycle after accept.
- Random: 1000 ops at WIDTH=32, with random in_valid/out_ready gaps -> every result equals {bout,d} = {1'b0,a} - {1'b0,b} - bin mod 2^33; no lost or duplicated transactions.
